neg_serial_ctrl: RTL and testbench
==================================

Name: neg_serial_ctrl

Overview:
Sequenced wide two's-complement negator (Z = -A) that reuses one narrow negation slice over several cycles, from least-significant slice to most-significant.
Used where a full-width prefix-AND negator is too large or too slow.
Valid/ready on input and output. Also reports the most-negative-operand overflow case.

Parameters:
width, 32, operand/result word width; must be a multiple of slice and >= 2
slice, 8, bits processed per cycle; 1 <= slice <= width
speed, 0, performance parameter of the prefix-AND structure inside the slice (0 serial, 1 Brent-Kung, 2 Sklansky)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
in_valid_i  in  1  operand valid
in_ready_o  out  1  block can accept an operand
A_i  in  width  operand
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
Z_o  out  width  result, -A mod 2^width
ovf_o  out  1  A was 2^(width-1) (result equals A); qualified by out_valid_o
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- NSL = width/slice.
- State machine states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, Z_o=0, ovf_o=0, busy_o=0. Internal counter=0, carry=1, zero-flag=1.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: capture A_i into the operand shift register, cnt=0, carry=1, lowzero=1; go to RUN.
- RUN:
  - in_ready_o=0. in_valid_i is ignored.
  - Each cycle, operate on the low slice of the shift register, as = A[cnt*slice +: slice]:
    - slice result = ~as ^ {prefixAND(~as)[slice-2:0], 1} when carry=1;
    - slice result = ~as when carry=0.
  - Update rule: carry <= carry & (&~as).
  - Shift the result into the result register, then shift the operand register right by slice.
  - Zero tracking: lowzero <= lowzero & (as==0) for every slice except the last. For the last slice, evaluate the top slice excluding its MSB.
  - After the NSL-th slice: go to DONE. Load Z_o from the result register. Set ovf_o = lowzero_final & A[width-1].
- DONE:
  - out_valid_o=1; in_ready_o=0.
  - Z_o and ovf_o are held stable until out_valid_o & out_ready_i; then go to IDLE.
  - There is no same-cycle accept in DONE.
- Latency:
  - Operand accepted in cycle t; out_valid_o first high in cycle t+NSL+1.
  - Minimum initiation interval is NSL+2 cycles when out_ready_i is held high.
- Z_o and ovf_o are output registers. They change only on RUN->DONE and keep their last value through IDLE and RUN.
- Arithmetic: modulo 2^width.
  - A=0 gives Z=0 with no carry-out flag.
  - A=2^(width-1) gives Z=A and ovf_o=1.
  - No other input sets ovf_o.
- Boundary conditions:
  - slice==width (NSL=1): single RUN cycle.
  - slice==1: counter width is $clog2(NSL).
  - Counter does not wrap; the transition is taken at cnt==NSL-1.
- Reset mid-operation (RUN or DONE): the in-flight operand is discarded and all registers return to reset values in the next cycle. out_valid_o is never asserted for the discarded operand.
- Illegal parameters (width % slice != 0, or width < 2): elaboration-time $error.

Decomposition:
- Package neg_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} neg_state_e. The state enum is the only type shared across blocks.
- Sub-module neg_slice (combinational):
  - Parameters slice, speed.
  - Ports: as, carry-in ci, result z, propagate-out po.
  - Wraps one prefix-AND structure of width slice: z = ~as ^ ({pp[slice-2:0],1} & {slice{ci}}), po = pp[slice-1].
- The controller holds the FSM, counter, shift registers, carry, and zero tracking. Expected size: ~200 lines.

Test Plan:
All scenarios use width=32, slice=8 (NSL=4).
1. A=0x00000001 accepted in cycle 0 -> out_valid_o first high in cycle 5, Z=0xFFFFFFFF, ovf_o=0; busy_o high cycles 1-5.
2. A=0x00000000 -> Z=0x00000000, ovf_o=0. A=0x00000100 -> Z=0xFFFFFF00; carry crosses a slice boundary. A=0xFFFFFFFF -> Z=0x00000001.
3. A=0x80000000 -> Z=0x80000000, ovf_o=1. A=0x80000001 -> Z=0x7FFFFFFF, ovf_o=0.
4. out_ready_i low for 3 cycles in DONE with in_valid_i high and A_i toggling -> Z_o/ovf_o stable, in_ready_o=0, new operand not taken. Raise out_ready_i -> IDLE next cycle, then accept.
5. rst_i pulsed in cycle 2 of RUN -> next cycle IDLE, Z_o=0, out_valid_o stays 0. Next operand A=5 -> Z=0xFFFFFFFB.
6. 1000 back-to-back random operands, out_ready_i random, speed in {0,1,2}, slice in {1,4,8,32} -> every Z_o equals -A mod 2^32, ovf_o matches the golden model, interval >= 6 cycles (NSL+2 for slice=8).

Source files
------------

// File: rtl/neg_pkg.sv
// Shared types for the sequenced two's-complement negator.
package neg_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} neg_state_e;

endpackage

// File: rtl/neg_slice.sv
// One slice of a two's-complement negator: z = ~as + ci, built on a prefix-AND of ~as.
// po reports that the whole slice propagates the incoming carry.
module neg_slice #(
  parameter int slice = 8,
  parameter int speed = 0
) (
  input  logic [slice-1:0] as,
  input  logic             ci,
  output logic [slice-1:0] z,
  output logic             po
);

  if (slice == 1) begin : g_bit
    assign z  = ~as ^ ci;
    assign po = ~as[0];
  end else begin : g_vec
    localparam int unsigned IW = $clog2(slice);
    localparam int unsigned LV = $clog2(slice);

    logic [slice-1:0] pp;

    // pp[i] = &(~as[i:0]); speed picks serial, Brent-Kung or Sklansky combining order
    always_comb begin
      pp = ~as;
      case (speed)
        1: begin
          for (int unsigned d = 0; d < LV; d++)
            for (int unsigned i = 0; i < slice; i++)
              if (((i + 1) % (2 << d)) == 0)
                pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - (1 << d))];
          for (int unsigned d = LV - 1; d > 0; d--)
            for (int unsigned i = 0; i < slice; i++)
              if (((i + 1) >= (3 << (d - 1))) && (((i + 1) % (2 << (d - 1))) == (1 << (d - 1))))
                pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - (1 << (d - 1)))];
        end
        2: begin
          for (int unsigned d = 0; d < LV; d++)
            for (int unsigned i = 0; i < slice; i++)
              if (((i >> d) & 1) != 0)
                pp[IW'(i)] = pp[IW'(i)] & pp[IW'(((i >> d) << d) - 1)];
        end
        default: begin
          for (int unsigned i = 1; i < slice; i++)
            pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - 1)];
        end
      endcase
    end

    assign z  = ~as ^ ({pp[slice-2:0], 1'b1} & {slice{ci}});
    assign po = pp[slice-1];
  end

endmodule

// File: rtl/neg_serial_ctrl.sv
// Wide negator Z = -A that walks one neg_slice across the operand, LSB slice first.
// Flags ovf_o when A is the most-negative value, whose negation is itself.
module neg_serial_ctrl
  import neg_pkg::*;
#(
  parameter int width = 32,
  parameter int slice = 8,
  parameter int speed = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] A_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] Z_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NSL = width / slice;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [slice-1:0] LOWMASK = ~(slice'(1) << (slice - 1));

  if ((slice < 1) || (slice > width) || (width < 2) || ((width % slice) != 0)) begin : g_bad
    $error("neg_serial_ctrl: width must be >= 2 and a multiple of slice");
  end

  neg_state_e       state;
  logic [width-1:0] opr;
  logic [width-1:0] res;
  logic [width-1:0] res_n;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             lowzero;
  logic [slice-1:0] as;
  logic [slice-1:0] zs;
  logic             po;
  logic             last;

  assign as   = opr[slice-1:0];
  assign last = (cnt == CW'(NSL - 1));
  // new slice enters at the top so the first slice lands at bit 0 after NSL shifts
  assign res_n = width'({zs, res} >> slice);

  neg_slice #(
    .slice(slice),
    .speed(speed)
  ) u_slice (
    .as(as),
    .ci(carry),
    .z (zs),
    .po(po)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      Z_o         <= '0;
      ovf_o       <= 1'b0;
      busy_o      <= 1'b0;
      cnt         <= '0;
      carry       <= 1'b1;
      lowzero     <= 1'b1;
      opr         <= '0;
      res         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            opr        <= A_i;
            cnt        <= '0;
            carry      <= 1'b1;
            lowzero    <= 1'b1;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res   <= res_n;
          opr   <= opr >> slice;
          carry <= carry & po;
          if (last) begin
            Z_o         <= res_n;
            // top slice must be exactly its sign bit, all lower slices zero
            ovf_o       <= lowzero & ((as & LOWMASK) == '0) & as[slice-1];
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            cnt     <= cnt + 1'b1;
            lowzero <= lowzero & (as == '0);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neg_serial_ctrl.sv
// Directed vectors on a width=32/slice=8 instance plus randomized traffic on several
// slice/speed configurations, all checked against -A mod 2^32.
module tb_neg_serial_ctrl;

  localparam int NCFG = 8;

  function automatic int cfg_slice(input int k);
    case (k)
      0, 1, 2: return 8;
      3, 4:    return 4;
      5, 6:    return 1;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_speed(input int k);
    case (k)
      0, 5:    return 0;
      1, 3, 7: return 1;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, iv, ir, ov, ordy, ovf, busy;
  logic [31:0] a, z;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          ndone = 0;
  int          t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neg_serial_ctrl #(
    .width(32),
    .slice(8),
    .speed(0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (iv),
    .in_ready_o (ir),
    .A_i        (a),
    .out_valid_o(ov),
    .out_ready_i(ordy),
    .Z_o        (z),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] val);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("send_ready", ir, 1'b1);
    check1("idle_busy", busy, 1'b0);
    a = val;
    iv = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    iv = 1'b0;
  endtask

  task automatic wait_valid(input logic [31:0] zprev, output int lat, output int nbusy,
                            output logic zheld);
    int n;
    n = 0;
    nbusy = 0;
    zheld = 1'b1;
    while (!ov && n < 40) begin
      if (busy) nbusy++;
      if (z !== zprev) zheld = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy) nbusy++;
    lat = cyc - t_acc;
  endtask

  task automatic take();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check1("post_take_valid", ov, 1'b0);
    check1("post_take_ready", ir, 1'b1);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat, nb;
    logic held;
    logic [31:0] zprev;
    zprev = z;
    send(v.a);
    wait_valid(zprev, lat, nb, held);
    check32({name, "_latency"}, lat, 32'd5);
    check32({name, "_busycycles"}, nb, 32'd5);
    check1({name, "_zheld"}, held, 1'b1);
    check32({name, "_z"}, z, v.z);
    check1({name, "_ovf"}, ovf, v.ovf);
    take();
  endtask

  initial begin : directed
    vec_t vecs[9];
    int lat, nb;
    logic held, sawv;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0100, 32'hFFFF_FF00, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[5] = '{32'h8000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'hEDCB_A988, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0001, 1'b0};
    vecs[8] = '{32'h0001_0000, 32'hFFFF_0000, 1'b0};

    rst = 1'b1; iv = 1'b0; a = '0; ordy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check1("rst_in_ready", ir, 1'b1);
    check1("rst_out_valid", ov, 1'b0);
    check32("rst_z", z, 32'h0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // stall in DONE with a competing operand on the input
    send(32'h0000_0010);
    wait_valid(z, lat, nb, held);
    check32("stall_latency", lat, 32'd5);
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1;
      a = (k % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      @(negedge clk);
      check32("stall_z", z, 32'hFFFF_FFF0);
      check1("stall_ovf", ovf, 1'b0);
      check1("stall_in_ready", ir, 1'b0);
      check1("stall_out_valid", ov, 1'b1);
    end
    a = 32'h0000_00FF;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check1("release_valid", ov, 1'b0);
    check1("release_ready", ir, 1'b1);
    t_acc = cyc;
    @(negedge clk);
    iv = 1'b0;
    wait_valid(32'hFFFF_FFF0, lat, nb, held);
    check32("after_stall_latency", lat, 32'd5);
    check32("after_stall_z", z, 32'hFFFF_FF01);
    check1("after_stall_zheld", held, 1'b1);
    take();

    // synchronous reset during RUN discards the operand
    send(32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("midrst_ready", ir, 1'b1);
    check1("midrst_valid", ov, 1'b0);
    check32("midrst_z", z, 32'h0);
    check1("midrst_ovf", ovf, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    sawv = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov) sawv = 1'b1;
    end
    check1("midrst_no_valid", sawv, 1'b0);
    run_vec("post_rst", '{32'h0000_0005, 32'hFFFF_FFFB, 1'b0});

    wait (ndone == NCFG);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", tests);
    $fatal(1);
  end

  for (genvar k = 0; k < NCFG; k++) begin : g_rnd
    localparam int S  = cfg_slice(k);
    localparam int SP = cfg_speed(k);
    localparam int NS = 32 / S;
    localparam int N  = (k == 0) ? 1000 : 120;

    logic        rrst, riv, rir, rov, rordy, rovf, rbusy;
    logic [31:0] ra, rz;

    neg_serial_ctrl #(
      .width(32),
      .slice(S),
      .speed(SP)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rrst),
      .in_valid_i (riv),
      .in_ready_o (rir),
      .A_i        (ra),
      .out_valid_o(rov),
      .out_ready_i(rordy),
      .Z_o        (rz),
      .ovf_o      (rovf),
      .busy_o     (rbusy)
    );

    initial begin : stim
      logic [31:0] q_a[$];
      int          q_t[$];
      int          sent, got, guard, limit, prev_acc;
      logic        first;
      logic [31:0] ea, v;

      sent = 0; got = 0; guard = 0; prev_acc = 0; first = 1'b1;
      limit = N * (NS + 2) * 8 + 200;
      rrst = 1'b1; riv = 1'b0; ra = '0; rordy = 1'b0;
      repeat (2) @(negedge clk);
      rrst = 1'b0;

      while (got < N && guard < limit) begin
        @(negedge clk);
        guard++;
        if (rov) begin
          if (q_a.size() == 0) begin
            check1($sformatf("cfg%0d_spurious_valid", k), rov, 1'b0);
          end else if (first) begin
            check32($sformatf("cfg%0d_latency", k), cyc - q_t[0], NS + 1);
            first = 1'b0;
          end
        end
        rordy = ($urandom_range(0, 1) == 1);
        if (rov && rordy && q_a.size() != 0) begin
          ea = q_a.pop_front();
          void'(q_t.pop_front());
          check32($sformatf("cfg%0d_z_of_%h", k, ea), rz, 32'd0 - ea);
          check1($sformatf("cfg%0d_ovf_of_%h", k, ea), rovf, ea == 32'h8000_0000);
          got++;
          first = 1'b1;
        end
        riv = (sent < N) && ($urandom_range(0, 3) != 0);
        if (riv) begin
          case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'h8000_0001;
            3: v = 32'hFFFF_FFFF;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
          endcase
          ra = v;
        end
        if (riv && rir) begin
          if (sent > 0)
            check1($sformatf("cfg%0d_interval", k), (cyc - prev_acc) >= NS + 2, 1'b1);
          q_a.push_back(ra);
          q_t.push_back(cyc);
          prev_acc = cyc;
          sent++;
        end
      end
      if (got < N) check32($sformatf("cfg%0d_timeout_results", k), got, N);
      riv = 1'b0;
      ndone++;
    end
  end

endmodule
